// File: rtl/mem_write_ctrl_if.sv
// CPU store bus and buffered RAM write port of mem_write_ctrl.
// The CPU side drives the cpu_* signals; the controller drives the ram_* and status signals.
interface mem_write_ctrl_if #(
   parameter int ADR_W = 16,
   parameter int DAT_W = 8
);
   logic             cpu_phi;
   logic [ADR_W-1:0] cpu_adr;
   logic [DAT_W-1:0] cpu_dbo;
   logic             cpu_we;

   logic [ADR_W-1:0] ram_adr;
   logic [DAT_W-1:0] ram_dbi;
   logic             ram_we;
   logic             wr_busy;
   logic             rom_wr_err;
   logic             wr_ovf;

   modport master (
      output cpu_phi, cpu_adr, cpu_dbo, cpu_we,
      input  ram_adr, ram_dbi, ram_we, wr_busy, rom_wr_err, wr_ovf
   );

   modport slave (
      input  cpu_phi, cpu_adr, cpu_dbo, cpu_we,
      output ram_adr, ram_dbi, ram_we, wr_busy, rom_wr_err, wr_ovf
   );
endinterface

// File: rtl/mem_write_ctrl.sv
// CPU-to-memory write path: holds one CPU store in a buffer and drives it into RAM
// during a CPU-owned write slot. Stores into the ROM window are refused.
module mem_write_ctrl #(
   parameter int              ADR_W     = 16,
   parameter int              DAT_W     = 8,
   parameter logic [ADR_W-1:0] RAM_TOP  = 16'hB000,
   parameter int unsigned     WE_CYCLES = 1
) (
   input  logic            mem_phi,
   input  logic            rst,
   mem_write_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // cnt holds the remaining ram_we cycles after the first one
   localparam logic [3:0] CNT_LOAD = 4'(WE_CYCLES - 1);

   state_t           state_q, state_d;
   logic             slot_q;
   logic             cpu_we_q;
   logic [3:0]       cnt_q,   cnt_d;
   logic [ADR_W-1:0] adr_q,   adr_d;
   logic [DAT_W-1:0] dat_q,   dat_d;
   logic             we_q,    we_d;
   logic             busy_q,  busy_d;
   logic             err_q,   err_d;
   logic             ovf_q,   ovf_d;

   logic req;
   logic is_ram;
   logic wr_slot;

   assign req     = bus.cpu_we & ~cpu_we_q;
   assign is_ram  = (bus.cpu_adr < RAM_TOP);
   assign wr_slot = slot_q & ~bus.cpu_phi;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      busy_d  = busy_q;
      err_d   = 1'b0;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (is_ram) begin
                  adr_d   = bus.cpu_adr;
                  dat_d   = bus.cpu_dbo;
                  busy_d  = 1'b1;
                  state_d = PEND;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end

         PEND: begin
            if (req) ovf_d = 1'b1;
            if (wr_slot) begin
               we_d    = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = WRITE;
            end
         end

         WRITE: begin
            // the buffer is still occupied on the last WRITE cycle, so a store here is dropped too
            if (req) ovf_d = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d   = cnt_q - 4'd1;
            end else begin
               we_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge mem_phi or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         slot_q   <= 1'b0;
         cpu_we_q <= 1'b0;
         cnt_q    <= 4'd0;
         adr_q    <= '0;
         dat_q    <= '0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         slot_q   <= ~slot_q;
         cpu_we_q <= bus.cpu_we;
         cnt_q    <= cnt_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.ram_adr    = adr_q;
   assign bus.ram_dbi    = dat_q;
   assign bus.ram_we     = we_q;
   assign bus.wr_busy    = busy_q;
   assign bus.rom_wr_err = err_q;
   assign bus.wr_ovf     = ovf_q;

   a_we_implies_busy : assert property (@(posedge mem_phi) disable iff (rst) we_q |-> busy_q);
   a_err_only_idle   : assert property (@(posedge mem_phi) disable iff (rst) err_q |-> !busy_q);

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Bench for mem_write_ctrl: hand-derived vector table, multi-cycle corner sequences and
// random traffic, all compared against a transaction-level reference model.
module tb_mem_write_ctrl;

   localparam logic [15:0] RAM_TOP = 16'hB000;

   logic        mem_phi = 1'b0;
   logic        rst     = 1'b0;
   logic        cpu_phi = 1'b0;
   logic        cpu_we  = 1'b0;
   logic [15:0] cpu_adr = '0;
   logic [7:0]  cpu_dbo = '0;

   always #5 mem_phi = ~mem_phi;

   mem_write_ctrl_if #(.ADR_W(16), .DAT_W(8)) bus1 ();
   mem_write_ctrl_if #(.ADR_W(16), .DAT_W(8)) bus3 ();

   assign bus1.cpu_phi = cpu_phi;
   assign bus1.cpu_adr = cpu_adr;
   assign bus1.cpu_dbo = cpu_dbo;
   assign bus1.cpu_we  = cpu_we;
   assign bus3.cpu_phi = cpu_phi;
   assign bus3.cpu_adr = cpu_adr;
   assign bus3.cpu_dbo = cpu_dbo;
   assign bus3.cpu_we  = cpu_we;

   mem_write_ctrl #(.ADR_W(16), .DAT_W(8), .RAM_TOP(RAM_TOP), .WE_CYCLES(1)) dut1 (
      .mem_phi (mem_phi),
      .rst     (rst),
      .bus     (bus1.slave)
   );

   mem_write_ctrl #(.ADR_W(16), .DAT_W(8), .RAM_TOP(RAM_TOP), .WE_CYCLES(3)) dut3 (
      .mem_phi (mem_phi),
      .rst     (rst),
      .bus     (bus3.slave)
   );

   // Reference model: one buffered store, the edge index its write began on, and flags.
   typedef struct {
      int          k;
      bit          prev_we;
      bit          have;
      int          wstart;
      logic [15:0] adr;
      logic [7:0]  dat;
      bit          err;
      bit          ovf;
   } mdl_t;

   localparam mdl_t MDL_RST = '{k: 0, prev_we: 1'b0, have: 1'b0, wstart: -1,
                                adr: 16'h0, dat: 8'h0, err: 1'b0, ovf: 1'b0};

   mdl_t m1, m3;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Slot value sampled on edge k after reset is k%2; a write may start on odd edges with cpu_phi low.
   function automatic mdl_t mdl_step(mdl_t m, int we_cycles, bit phi, bit we,
                                     logic [15:0] adr, logic [7:0] dat);
      bit req;
      req   = we && !m.prev_we;
      m.err = 1'b0;
      if (m.have) begin
         if (req) m.ovf = 1'b1;
         if (m.wstart < 0) begin
            if ((m.k % 2 == 1) && !phi) m.wstart = m.k;
         end else if (m.k - m.wstart == we_cycles) begin
            m.have   = 1'b0;
            m.wstart = -1;
         end
      end else if (req) begin
         if (adr < RAM_TOP) begin
            m.have   = 1'b1;
            m.wstart = -1;
            m.adr    = adr;
            m.dat    = dat;
         end else begin
            m.err = 1'b1;
         end
      end
      m.prev_we = we;
      m.k++;
      return m;
   endfunction

   // Output vector layout: {ram_adr, ram_dbi, ram_we, wr_busy, rom_wr_err, wr_ovf}
   function automatic logic [27:0] mdl_out(mdl_t m);
      return {m.adr, m.dat, (m.have && m.wstart >= 0), m.have, m.err, m.ovf};
   endfunction

   function automatic logic [27:0] dut_out1();
      return {bus1.ram_adr, bus1.ram_dbi, bus1.ram_we, bus1.wr_busy, bus1.rom_wr_err, bus1.wr_ovf};
   endfunction

   function automatic logic [27:0] dut_out3();
      return {bus3.ram_adr, bus3.ram_dbi, bus3.ram_we, bus3.wr_busy, bus3.rom_wr_err, bus3.wr_ovf};
   endfunction

   function automatic logic [27:0] mk(logic [15:0] adr, logic [7:0] dat,
                                      bit we, bit busy, bit err, bit ovf);
      return {adr, dat, we, busy, err, ovf};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock: models see the same inputs the DUTs sample, outputs compared 1ns after the edge.
   task automatic tick();
      @(posedge mem_phi);
      m1 = mdl_step(m1, 1, cpu_phi, cpu_we, cpu_adr, cpu_dbo);
      m3 = mdl_step(m3, 3, cpu_phi, cpu_we, cpu_adr, cpu_dbo);
      #1;
      check("model_we1", dut_out1(), mdl_out(m1));
      check("model_we3", dut_out3(), mdl_out(m3));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_out_we1", dut_out1(), 28'h0);
      check("rst_out_we3", dut_out3(), 28'h0);
      cpu_we  = 1'b0;
      cpu_phi = 1'b0;
      repeat (2) @(posedge mem_phi);
      @(negedge mem_phi);
      rst = 1'b0;
      m1  = MDL_RST;
      m3  = MDL_RST;
   endtask

   typedef struct {
      logic        phi;
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dbo;
      logic [27:0] exp;
   } vec_t;

   vec_t vt[17];

   initial begin
      int np, nh, first;
      bit prev, seen;
      logic [15:0] pick[5];

      // Expected values for the WE_CYCLES=1 instance, edge 0 being the first edge after reset.
      vt[0]  = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(16'h0000, 8'h00, 0, 0, 0, 0)};
      vt[1]  = '{1'b0, 1'b1, 16'h1234, 8'hA5, mk(16'h1234, 8'hA5, 0, 1, 0, 0)};
      vt[2]  = '{1'b0, 1'b1, 16'h1234, 8'hA5, mk(16'h1234, 8'hA5, 0, 1, 0, 0)};
      vt[3]  = '{1'b0, 1'b0, 16'h1234, 8'hA5, mk(16'h1234, 8'hA5, 1, 1, 0, 0)};
      vt[4]  = '{1'b0, 1'b0, 16'h1234, 8'hA5, mk(16'h1234, 8'hA5, 0, 0, 0, 0)};
      vt[5]  = '{1'b0, 1'b1, 16'hB000, 8'h11, mk(16'h1234, 8'hA5, 0, 0, 1, 0)};
      vt[6]  = '{1'b0, 1'b1, 16'hB000, 8'h11, mk(16'h1234, 8'hA5, 0, 0, 0, 0)};
      vt[7]  = '{1'b0, 1'b0, 16'hB000, 8'h11, mk(16'h1234, 8'hA5, 0, 0, 0, 0)};
      vt[8]  = '{1'b0, 1'b1, 16'hAFFF, 8'h3C, mk(16'hAFFF, 8'h3C, 0, 1, 0, 0)};
      vt[9]  = '{1'b0, 1'b0, 16'hAFFF, 8'h3C, mk(16'hAFFF, 8'h3C, 1, 1, 0, 0)};
      vt[10] = '{1'b0, 1'b0, 16'hAFFF, 8'h3C, mk(16'hAFFF, 8'h3C, 0, 0, 0, 0)};
      vt[11] = '{1'b0, 1'b1, 16'hFFFF, 8'h77, mk(16'hAFFF, 8'h3C, 0, 0, 1, 0)};
      vt[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(16'hAFFF, 8'h3C, 0, 0, 0, 0)};
      vt[13] = '{1'b0, 1'b1, 16'h0000, 8'h9E, mk(16'h0000, 8'h9E, 0, 1, 0, 0)};
      vt[14] = '{1'b0, 1'b0, 16'h0000, 8'h9E, mk(16'h0000, 8'h9E, 0, 1, 0, 0)};
      vt[15] = '{1'b0, 1'b0, 16'h0000, 8'h9E, mk(16'h0000, 8'h9E, 1, 1, 0, 0)};
      vt[16] = '{1'b0, 1'b0, 16'h0000, 8'h9E, mk(16'h0000, 8'h9E, 0, 0, 0, 0)};

      m1 = MDL_RST;
      m3 = MDL_RST;
      #2;
      do_reset();

      // RAM store, ROM refusal and address boundaries
      for (int i = 0; i < 17; i++) begin
         // NOTE: inputs are driven with blocking assignments between edges, never on an edge.
         cpu_phi = vt[i].phi;
         cpu_we  = vt[i].we;
         cpu_adr = vt[i].adr;
         cpu_dbo = vt[i].dbo;
         tick();
         check($sformatf("vec%0d", i), dut_out1(), vt[i].exp);
      end

      // Slot wait with cpu_phi high, and a second store arriving while pending
      cpu_phi = 1'b1;
      cpu_adr = 16'h0100;
      cpu_dbo = 8'hA5;
      cpu_we  = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         cpu_we  = (i == 4);
         cpu_dbo = (i >= 4) ? 8'h5A : 8'hA5;
         tick();
         check("t4_wait_busy_no_we", {bus1.wr_busy, bus1.ram_we}, 2'b10);
      end
      check("t5_ovf_set", bus1.wr_ovf, 1'b1);
      check("t5_dbi_kept", bus1.ram_dbi, 8'hA5);
      cpu_phi = 1'b0;
      np = 0; first = -1; prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus1.ram_we && !prev) begin
            np++;
            if (first < 0) first = i;
         end
         prev = bus1.ram_we;
      end
      check("t4_write_at_next_slot", (first >= 0 && first <= 1), 1'b1);
      check("t5_one_pulse", np, 1);
      check("t5_ovf_sticky", bus1.wr_ovf, 1'b1);

      // Three-cycle write pulse with a held strobe
      cpu_we = 1'b0;
      tick();
      cpu_adr = 16'h2000;
      cpu_dbo = 8'hC3;
      cpu_we  = 1'b1;
      np = 0; nh = 0; prev = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus3.ram_we) nh++;
         if (bus3.ram_we && !prev) np++;
         prev = bus3.ram_we;
      end
      check("t6_we_width", nh, 3);
      check("t6_single_request", np, 1);
      check("t6_adr", bus3.ram_adr, 16'h2000);

      // Reset in the middle of a write
      cpu_we = 1'b0;
      tick();
      cpu_adr = 16'h0456;
      cpu_dbo = 8'h81;
      cpu_we  = 1'b1;
      tick();
      cpu_we = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         tick();
         seen = bus3.ram_we;
      end
      check("t1_reached_write", seen, 1'b1);
      do_reset();
      tick();
      check("t1_idle_after_release", {bus3.wr_busy, bus3.ram_we, bus1.wr_busy, bus1.wr_ovf}, 4'b0000);

      // Random traffic against the model
      pick[0] = 16'h0000;
      pick[1] = 16'hAFFF;
      pick[2] = 16'hB000;
      pick[3] = 16'hFFFF;
      pick[4] = 16'h0000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) cpu_phi = ~cpu_phi;
         if ($urandom_range(0, 2) == 0) cpu_we  = ~cpu_we;
         if ($urandom_range(0, 1) == 0) cpu_adr = 16'($urandom);
         else                           cpu_adr = pick[$urandom_range(0, 4)];
         cpu_dbo = 8'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
